// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser: assembles SYNC/CMD/ARG[/CHK] byte frames from an SPI slave into commands,
// with inter-byte timeout and saturating error count. Define SPI_CMD_CHECKSUM_EN for the CHK byte.
module spi_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 25000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int unsigned    TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_ONE  = TW'(1);

  typedef enum logic [1:0] {IDLE, GET_CMD, GET_ARG, GET_CHK} state_t;

  state_t        state;
  logic [7:0]    cmd_reg;
  logic [TW-1:0] tmo_cnt;
`ifdef SPI_CMD_CHECKSUM_EN
  logic [7:0]    arg_reg;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_reg   <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
      arg_reg   <= '0;
`endif
      tmo_cnt   <= '0;
      cmd_valid <= 1'b0;
      err_pulse <= 1'b0;
      cmd_code  <= '0;
      cmd_arg   <= '0;
      err_count <= '0;
    end else begin
      cmd_valid <= 1'b0;
      err_pulse <= 1'b0;

      if (state == IDLE || rx_valid)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TMO_ONE;

      // A byte arriving on the expiry cycle wins over the timeout.
      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC_BYTE)
              state <= GET_CMD;
          end
          GET_CMD: begin
            cmd_reg <= rx_data;
            state   <= GET_ARG;
          end
          GET_ARG: begin
`ifdef SPI_CMD_CHECKSUM_EN
            arg_reg <= rx_data;
            state   <= GET_CHK;
`else
            cmd_code  <= cmd_reg;
            cmd_arg   <= rx_data;
            cmd_valid <= 1'b1;
            state     <= IDLE;
`endif
          end
          default: begin
`ifdef SPI_CMD_CHECKSUM_EN
            if (rx_data == (cmd_reg ^ arg_reg)) begin
              cmd_code  <= cmd_reg;
              cmd_arg   <= arg_reg;
              cmd_valid <= 1'b1;
            end else begin
              err_pulse <= 1'b1;
              if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            end
`endif
            state <= IDLE;
          end
        endcase
      end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
        state     <= IDLE;
        err_pulse <= 1'b1;
        if (err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Scoreboard bench for spi_cmd_parser: stimulus pushes expected pulses, a negedge monitor pops and checks them.
module tb_spi_cmd_parser;

  localparam int unsigned TMO  = 20;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_arg;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       busy;

  always #5 clk = ~clk;

  spi_cmd_parser #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
    .err_pulse(err_pulse), .err_count(err_count), .busy(busy)
  );

  typedef struct {
    logic        is_err;
    logic [7:0]  code;
    logic [7:0]  arg;
    logic [7:0]  ecnt;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  logic [7:0]  m_code = 8'h00;
  logic [7:0]  m_arg  = 8'h00;
  logic [7:0]  m_ecnt = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (cmd_valid || err_pulse) begin
      exp_t e;
      check("pulse_exclusive", {31'd0, cmd_valid & err_pulse}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, cmd_valid, err_pulse}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {31'd0, err_pulse}, {31'd0, e.is_err});
        check("pulse_cycle", cyc, e.due);
        check("cmd_code", {24'd0, cmd_code}, {24'd0, e.code});
        check("cmd_arg", {24'd0, cmd_arg}, {24'd0, e.arg});
        check("err_count", {24'd0, err_count}, {24'd0, e.ecnt});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ok(input logic [7:0] code, input logic [7:0] arg);
    m_code = code;
    m_arg  = arg;
    sb.push_back('{1'b0, code, arg, m_ecnt, cyc});
  endtask

  task automatic push_err(input int unsigned due);
    if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
    sb.push_back('{1'b1, m_code, m_arg, m_ecnt, due});
  endtask

  task automatic send_tail(input logic [7:0] code, input logic [7:0] arg);
    send_byte(arg);
`ifdef SPI_CMD_CHECKSUM_EN
    send_byte(code ^ arg);
`endif
    push_ok(code, arg);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic [7:0] arg);
    send_byte(SYNC);
    send_byte(code);
    send_tail(code, arg);
  endtask

  task automatic bad_frame(input logic [7:0] code, input logic [7:0] arg);
    send_byte(SYNC);
    send_byte(code);
`ifdef SPI_CMD_CHECKSUM_EN
    send_byte(arg);
    send_byte(code ^ arg ^ 8'h01);
    push_err(cyc);
    idle_cycles(1);
`else
    push_err(cyc + TMO);
    idle_cycles(TMO + 1);
`endif
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion expected test end before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a sync strobe held high: must be ignored.
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = SYNC;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_code", {24'd0, cmd_code}, 32'd0);
    check("rst_arg", {24'd0, cmd_arg}, 32'd0);
    check("rst_errcnt", {24'd0, err_count}, 32'd0);
    check("rst_valid", {30'd0, cmd_valid, err_pulse}, 32'd0);

    // Basic accepted frame.
    send_byte(SYNC);
    check("busy_after_sync", {31'd0, busy}, 32'd1);
    send_byte(8'h10);
    send_tail(8'h10, 8'h5A);
    idle_cycles(2);
    check("busy_after_frame", {31'd0, busy}, 32'd0);

`ifdef SPI_CMD_CHECKSUM_EN
    // Bad checksum: error, outputs unchanged.
    send_byte(SYNC);
    send_byte(8'h10);
    send_byte(8'h5A);
    send_byte(8'h00);
    push_err(cyc);
    idle_cycles(2);
    check("chk_err_count", {24'd0, err_count}, {24'd0, m_ecnt});
`endif

    // Leading junk is dropped without error.
    send_byte(8'h00);
    send_byte(8'hFF);
    check("junk_not_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h20, 8'h01);

    // Sync value in the CMD slot is data.
    send_frame(SYNC, 8'h07);
    idle_cycles(2);

    // Timeout: still busy one cycle before expiry, idle at expiry.
    begin
      int unsigned c0;
      send_byte(SYNC);
      send_byte(8'h10);
      c0 = cyc;
      push_err(c0 + TMO);
      idle_cycles(TMO - 1);
      check("tmo_busy_before", {31'd0, busy}, 32'd1);
      idle_cycles(1);
      check("tmo_busy_after", {31'd0, busy}, 32'd0);
    end
    send_frame(8'h11, 8'h22);
    idle_cycles(2);

    // Byte landing exactly on the expiry cycle is processed, no timeout.
    send_byte(SYNC);
    send_byte(8'h40);
    idle_cycles(TMO - 1);
    send_tail(8'h40, 8'h41);
    idle_cycles(TMO + 2);

    // Reset mid-frame discards it silently and clears outputs.
    send_byte(SYNC);
    send_byte(8'h10);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    m_code = 8'h00;
    m_arg  = 8'h00;
    m_ecnt = 8'h00;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_code", {24'd0, cmd_code}, 32'd0);
    check("midrst_errcnt", {24'd0, err_count}, 32'd0);
    idle_cycles(TMO + 2);
    send_frame(8'h30, 8'h02);
    idle_cycles(2);

    // Saturation of the error counter.
    for (int i = 0; i < 256; i++)
      bad_frame(8'(i), 8'h33);
    idle_cycles(2);
    check("sat_errcnt", {24'd0, err_count}, 32'hFF);
    send_frame(8'h55, 8'h66);
    idle_cycles(3);
    check("final_code", {24'd0, cmd_code}, 32'h55);
    check("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_parser.md
SPI_CMD_PARSER -- requirements
Module: spi_cmd_parser

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 25000, inter-byte timeout in clk cycles (1 ms at 25 MHz).
REQ-002 Parameter: SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 Port: clk  input  1  25 MHz system clock; the single clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: rx_data  input  8  byte from SPI slave; valid only while rx_valid=1.
REQ-006 Port: rx_valid  input  1  one-cycle strobe per received byte.
REQ-007 Port: cmd_valid  output  1  one-cycle pulse; a complete, accepted frame.
REQ-008 Port: cmd_code  output  8  command byte of last accepted frame.
REQ-009 Port: cmd_arg  output  8  argument byte of last accepted frame.
REQ-010 Port: err_pulse  output  1  one-cycle pulse on a checksum or timeout error.
REQ-011 Port: err_count  output  8  saturating error counter.
REQ-012 Port: busy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-013 Frame: SYNC_BYTE, CMD, ARG, then CHK when checksum is enabled (see Configuration).
REQ-014 FSM states: IDLE, GET_CMD, GET_ARG, GET_CHK; only bytes with rx_valid=1 advance the FSM.
REQ-015 IDLE: rx_data==SYNC_BYTE -> GET_CMD; any other byte is dropped silently, with no error.
REQ-016 GET_CMD: byte latched to an internal cmd register -> GET_ARG; a SYNC_BYTE value here is data, not a resync.
REQ-017 GET_ARG: byte latched -> GET_CHK if checksum is enabled, else accept the frame -> IDLE.
REQ-018 GET_CHK: rx_data == (CMD ^ ARG) -> accept the frame; mismatch -> error; both cases -> IDLE.
REQ-019 Accept: cmd_code/cmd_arg updated and cmd_valid=1 in the cycle after the final byte's rx_valid (latency 1).
REQ-020 cmd_code/cmd_arg hold their value until the next accepted frame; rejected frames never alter them.
REQ-021 Timeout: counter clears on every rx_valid and while in IDLE; it increments in other states.
REQ-022 On count == TIMEOUT_CYCLES-1 with no rx_valid -> IDLE, with one err_pulse.
REQ-023 If rx_valid coincides with timeout expiry, the byte is processed and the timeout is ignored.
REQ-024 err_pulse lasts one cycle, registered, in the cycle after the error event.
REQ-025 err_count increments by 1 per error and saturates at 8'hFF (no wrap).
REQ-026 cmd_valid and err_pulse are never both high in the same cycle.

Reset
REQ-027 rst=1 at a clock edge forces: state=IDLE, cmd_valid=0, err_pulse=0, busy=0, cmd_code=0, cmd_arg=0, err_count=0, timeout counter=0.
REQ-028 Reset mid-frame discards the partial frame without an error.
REQ-029 rx_valid during a reset cycle is ignored.

Configuration
REQ-030 Macro SPI_CMD_CHECKSUM_EN defined: 4-byte frame, GET_CHK state present, checksum errors counted.
REQ-031 Macro undefined: 3-byte frame, GET_CHK is unreachable or removed, errors come only from timeout.

Verification
REQ-032 Checksum on: bytes A5,10,5A,4A -> cmd_valid one cycle after the 4A strobe; cmd_code=10, cmd_arg=5A; err_count=0.
REQ-033 Checksum on: bytes A5,10,5A,00 -> no cmd_valid; err_pulse=1; err_count=1; cmd_code/cmd_arg unchanged.
REQ-034 Bytes 00,FF,A5,20,01(,21) -> the leading 00 and FF are ignored; accepted frame has cmd_code=20, cmd_arg=01.
REQ-035 Bytes A5,10, then a gap of TIMEOUT_CYCLES clocks -> err_pulse=1; busy falls; the next A5 starts a fresh frame.
REQ-036 rst asserted after A5,10 -> busy=0; a following frame A5,30,02(,32) is accepted normally.
REQ-037 Force 256 bad frames -> err_count stays at FF; the next good frame still produces cmd_valid.
